// File: rtl/alu_pkg.sv
// Shared types and constants for the two-port ALU arbiter and its datapath.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE = 2'd0;
    localparam arb_state_t EXEC = 2'd1;
    localparam arb_state_t RESP = 2'd2;

    localparam int DEFAULT_DATA_WIDTH = 5;

endpackage

// File: rtl/alu.sv
// Shared ALU datapath: ADD/SUB/AND/OR with wraparound arithmetic and a zero flag.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data_rs1,
    input  logic [DATA_WIDTH-1:0] source_2,
    input  alu_op_t               alu_op,
    output logic [DATA_WIDTH-1:0] ALU_result,
    output logic                  zero
);

    always_comb begin
        ALU_result = '0;
        case (alu_op)
            ALU_ADD: ALU_result = data_rs1 + source_2;
            ALU_SUB: ALU_result = data_rs1 - source_2;
            ALU_AND: ALU_result = data_rs1 & source_2;
            ALU_OR:  ALU_result = data_rs1 | source_2;
            default: ALU_result = '0;
        endcase
    end

    assign zero = (ALU_result == '0);

endmodule

// File: rtl/alu_rr_arb2.sv
// Two-way grant selection. Defining ALU_SHARE_ARBITER_FIXED_PRIO_EN makes
// requester 0 win every contested cycle instead of alternating.
module alu_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant_id,
    output logic       grant_valid
);

`ifdef ALU_SHARE_ARBITER_FIXED_PRIO_EN
    localparam bit ROUND_ROBIN = 1'b0;
`else
    localparam bit ROUND_ROBIN = 1'b1;
`endif

    always_comb begin
        grant_valid = |valid;
        grant_id    = 1'b0;
        if (valid == 2'b11)
            grant_id = ROUND_ROBIN ? ~last_grant : 1'b0;
        else
            grant_id = valid[1];
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two valid/ready requesters; build option
// ALU_SHARE_ARBITER_FIXED_PRIO_EN selects fixed priority in alu_rr_arb2.
//
//  state | meaning
//  IDLE  | waiting for a request; grant offered combinationally via reqN_ready
//  EXEC  | ALU evaluates captured operands; result loads into rsp{grant}
//  RESP  | response held until rsp{grant}_ready handshake
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [1:0]            req0_op,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [1:0]            req1_op,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,

    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DATA_WIDTH-1:0] rsp0_result,
    output logic                  rsp0_zero,

    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp1_result,
    output logic                  rsp1_zero,

    output logic                  busy
);

    arb_state_t            state;
    logic                  last_grant;
    logic                  grant_q;
    logic                  grant_id;
    logic                  grant_valid;
    logic                  rsp_ack;
    alu_op_t               op_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_zero;

    alu_rr_arb2 u_arb (
        .valid       ({req1_valid, req0_valid}),
        .last_grant  (last_grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .data_rs1   (a_q),
        .source_2   (b_q),
        .alu_op     (op_q),
        .ALU_result (alu_result),
        .zero       (alu_zero)
    );

    // Ready is gated by rst so nothing is offered while reset is held.
    assign req0_ready = ~rst && (state == IDLE) && grant_valid && ~grant_id;
    assign req1_ready = ~rst && (state == IDLE) && grant_valid &&  grant_id;
    assign rsp_ack    = grant_q ? rsp1_ready : rsp0_ready;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            grant_q     <= 1'b0;
            op_q        <= ALU_ADD;
            a_q         <= '0;
            b_q         <= '0;
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp0_zero   <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
            rsp1_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        grant_q    <= grant_id;
                        last_grant <= grant_id;
                        op_q       <= grant_id ? alu_op_t'(req1_op) : alu_op_t'(req0_op);
                        a_q        <= grant_id ? req1_a : req0_a;
                        b_q        <= grant_id ? req1_b : req0_b;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (grant_q) begin
                        rsp1_valid  <= 1'b1;
                        rsp1_result <= alu_result;
                        rsp1_zero   <= alu_zero;
                    end else begin
                        rsp0_valid  <= 1'b1;
                        rsp0_result <= alu_result;
                        rsp0_zero   <= alu_zero;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ack) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
